// File: rtl/decode_pkg.sv
// Shared types, condition codes and the field-split function for the decode stage.
package decode_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned MAX_IMM_W = 64;

  typedef enum logic [1:0] {
    OP_DP  = 2'd0,
    OP_MEM = 2'd1,
    OP_BR  = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Queue entry: raw instruction and its PC
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_t;

  // Decoded fields at their natural width; the top level resizes rn/rm/rd and imm
  typedef struct packed {
    op_e                  op;
    logic [5:0]           funct;
    logic [3:0]           cond;
    logic [IDX_W-1:0]     rn;
    logic [IDX_W-1:0]     rm;
    logic [IDX_W-1:0]     rd;
    logic [MAX_IMM_W-1:0] imm;
    logic [3:0]           rot;
    logic [PC_W-1:0]      pc;
    logic                 illegal;
  } decoded_instr_t;

  // Split a raw instruction into its fields; unused fields stay zero
  function automatic decoded_instr_t decode(input logic [INSTR_W-1:0] instr,
                                            input logic [PC_W-1:0] pc);
    decoded_instr_t d;
    d      = '0;
    d.op   = op_e'(instr[27:26]);
    d.cond = instr[31:28];
    d.pc   = pc;
    case (d.op)
      OP_DP: begin
        d.funct = instr[25:20];
        d.rn    = instr[19:16];
        d.rd    = instr[15:12];
        if (instr[25]) begin
          d.imm = MAX_IMM_W'(instr[7:0]);
          d.rot = instr[11:8];
        end else begin
          d.rm  = instr[3:0];
        end
      end
      OP_MEM: begin
        d.funct = instr[25:20];
        d.rn    = instr[19:16];
        d.rd    = instr[15:12];
        if (instr[25]) d.rm  = instr[3:0];
        else           d.imm = MAX_IMM_W'(instr[11:0]);
      end
      OP_BR: begin
        d.funct = {4'b0000, instr[25:24]};
        d.imm   = {{38{instr[23]}}, instr[23:0], 2'b00};
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  // NZCV condition check; the reserved code 4'hF never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic r;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = c;
      COND_CC: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !c || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic power-of-two circular queue with synchronous clear.
module instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         clear,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage write; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Back-pressured instruction decode stage: queue, decode, output register.
// Optional macro COND_EVAL_EN: out_exec evaluates out_cond against live flags;
// without it out_exec is tied high.
module instr_decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned REG_W = 4,
  parameter int unsigned IMM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  input  logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [5:0]       out_funct,
  output logic [3:0]       out_cond,
  output logic [REG_W-1:0] out_rn,
  output logic [REG_W-1:0] out_rm,
  output logic [REG_W-1:0] out_rd,
  output logic [IMM_W-1:0] out_imm,
  output logic [3:0]       out_rot,
  output logic [31:0]      out_pc,
  output logic             out_illegal,
  output logic             out_exec
);

  localparam int unsigned ENTRY_W = $bits(fetch_t);

  fetch_t         in_entry;
  fetch_t         head;
  logic           full;
  logic           empty;
  logic           load;
  decoded_instr_t dec;

  assign in_entry = '{instr: in_instr, pc: in_pc};
  assign in_ready = !full && !flush;
  assign load     = !empty && (!out_valid || out_ready);
  assign dec      = decode(head.instr, head.pc);

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .din   (in_entry),
    .pop   (load),
    .clear (flush),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Output register: flush squashes, otherwise load the head or drain when taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_funct   <= '0;
      out_cond    <= '0;
      out_rn      <= '0;
      out_rm      <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_rot     <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_op      <= dec.op;
      out_funct   <= dec.funct;
      out_cond    <= dec.cond;
      out_rn      <= REG_W'(dec.rn);
      out_rm      <= REG_W'(dec.rm);
      out_rd      <= REG_W'(dec.rd);
      out_imm     <= IMM_W'(dec.imm);
      out_rot     <= dec.rot;
      out_pc      <= dec.pc;
      out_illegal <= dec.illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef COND_EVAL_EN
  assign out_exec = cond_pass(out_cond, flags);
`else
  logic unused_flags;
  assign unused_flags = ^flags;
  assign out_exec     = 1'b1;
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed self-checking bench for instr_decode_pipe (DEPTH=2, plus a REG_W=5 copy).
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready5;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [3:0]  flags;
  logic        out_valid, out_valid5;
  logic        out_ready;
  logic [1:0]  out_op, out_op5;
  logic [5:0]  out_funct, out_funct5;
  logic [3:0]  out_cond, out_cond5;
  logic [3:0]  out_rn, out_rm, out_rd;
  logic [4:0]  out_rn5, out_rm5, out_rd5;
  logic [31:0] out_imm, out_imm5;
  logic [3:0]  out_rot, out_rot5;
  logic [31:0] out_pc, out_pc5;
  logic        out_illegal, out_illegal5;
  logic        out_exec, out_exec5;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_decode_pipe #(.DEPTH(2), .REG_W(4), .IMM_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_funct(out_funct), .out_cond(out_cond), .out_rn(out_rn),
    .out_rm(out_rm), .out_rd(out_rd), .out_imm(out_imm), .out_rot(out_rot),
    .out_pc(out_pc), .out_illegal(out_illegal), .out_exec(out_exec)
  );

  instr_decode_pipe #(.DEPTH(2), .REG_W(5), .IMM_W(32)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .flags(flags),
    .out_valid(out_valid5), .out_ready(out_ready), .out_op(out_op5),
    .out_funct(out_funct5), .out_cond(out_cond5), .out_rn(out_rn5),
    .out_rm(out_rm5), .out_rd(out_rd5), .out_imm(out_imm5), .out_rot(out_rot5),
    .out_pc(out_pc5), .out_illegal(out_illegal5), .out_exec(out_exec5)
  );

  // Count one comparison and report it on mismatch
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Compare the whole decoded output against expected fields
  task automatic check_out(input string tag, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                           input logic [31:0] imm, input logic [3:0] rot,
                           input logic [31:0] pc, input logic illegal);
    check({tag, ".valid"},   64'(out_valid),   64'(1));
    check({tag, ".op"},      64'(out_op),      64'(op));
    check({tag, ".funct"},   64'(out_funct),   64'(funct));
    check({tag, ".rn"},      64'(out_rn),      64'(rn));
    check({tag, ".rm"},      64'(out_rm),      64'(rm));
    check({tag, ".rd"},      64'(out_rd),      64'(rd));
    check({tag, ".imm"},     64'(out_imm),     64'(imm));
    check({tag, ".rot"},     64'(out_rot),     64'(rot));
    check({tag, ".pc"},      64'(out_pc),      64'(pc));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(illegal));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    #1;
  endtask

  logic exp_ne_z;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    flags     = 4'b0000;
    out_ready = 1'b1;
    #12;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.in_ready",  64'(in_ready),  64'(1));
    check("rst.imm",       64'(out_imm),   64'(0));
    check("rst.rd",        64'(out_rd),    64'(0));
    check("rst.pc",        64'(out_pc),    64'(0));
    check("rst.illegal",   64'(out_illegal), 64'(0));
    step();
    rst_n = 1'b1;
    step();

    // Data-processing immediate, two-cycle latency
    drive(1'b1, 32'hE3A01005, 32'h0000_0100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("dpi.lat1", 64'(out_valid), 64'(0));
    step();
    check_out("dpi", 2'd0, 6'h3A, 4'd0, 4'd0, 4'd1, 32'd5, 4'd0, 32'h100, 1'b0);
    check("dpi.exec", 64'(out_exec), 64'(1));
    step();
    check("dpi.drain", 64'(out_valid), 64'(0));

    // Back-to-back stream: branch, memory, illegal, DP register
    drive(1'b1, 32'hEAFFFFFE, 32'h0000_0200);
    step();
    drive(1'b1, 32'hE5912004, 32'h0000_0204);
    step();
    check_out("br", 2'd2, 6'h02, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFF8, 4'd0, 32'h200, 1'b0);
    drive(1'b1, 32'hEC000000, 32'h0000_0208);
    step();
    check_out("mem", 2'd1, 6'h19, 4'd1, 4'd0, 4'd2, 32'd4, 4'd0, 32'h204, 1'b0);
    check("mem.rn5", 64'(out_rn5), 64'(5'b00001));
    drive(1'b1, 32'hE0812003, 32'h0000_020C);
    step();
    check_out("ill", 2'd3, 6'h00, 4'd0, 4'd0, 4'd0, 32'd0, 4'd0, 32'h208, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check_out("dpr", 2'd0, 6'h08, 4'd1, 4'd3, 4'd2, 32'd0, 4'd0, 32'h20C, 1'b0);
    step();
    check("stream.drain", 64'(out_valid), 64'(0));

    // Back-pressure: DEPTH+1 accepted, then full
    out_ready = 1'b0;
    drive(1'b1, 32'hE3A00011, 32'h0000_0300);
    check("bp.rdy0", 64'(in_ready), 64'(1));
    step();
    drive(1'b1, 32'hE3A00022, 32'h0000_0304);
    check("bp.rdy1", 64'(in_ready), 64'(1));
    step();
    check("bp.first", 64'(out_imm), 64'(32'h11));
    drive(1'b1, 32'hE3A00033, 32'h0000_0308);
    check("bp.rdy2", 64'(in_ready), 64'(1));
    step();
    drive(1'b1, 32'hE3A00044, 32'h0000_030C);
    check("bp.full", 64'(in_ready), 64'(0));
    step();
    check("bp.hold.imm", 64'(out_imm), 64'(32'h11));
    check("bp.hold.pc",  64'(out_pc),  64'(32'h300));
    check("bp.hold.v",   64'(out_valid), 64'(1));
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    check("bp.d1.imm", 64'(out_imm), 64'(32'h22));
    check("bp.d1.pc",  64'(out_pc),  64'(32'h304));
    step();
    check("bp.d2.imm", 64'(out_imm), 64'(32'h33));
    check("bp.d2.v",   64'(out_valid), 64'(1));
    step();
    check("bp.empty", 64'(out_valid), 64'(0));

    // Flush with the queue full and the output occupied
    out_ready = 1'b0;
    drive(1'b1, 32'hE3A00055, 32'h0000_0400);
    step();
    drive(1'b1, 32'hE3A00066, 32'h0000_0404);
    step();
    drive(1'b1, 32'hE3A00077, 32'h0000_0408);
    step();
    check("fl.pre.v",    64'(out_valid), 64'(1));
    check("fl.pre.full", 64'(in_ready),  64'(0));
    flush = 1'b1;
    drive(1'b1, 32'hE3A00088, 32'h0000_040C);
    check("fl.rdy", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl.v",   64'(out_valid), 64'(0));
    check("fl.rdy_after", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    step();
    check("fl.dropped", 64'(out_valid), 64'(0));
    step();
    check("fl.still_empty", 64'(out_valid), 64'(0));

    // Condition evaluation on a held NE instruction
    out_ready = 1'b0;
    drive(1'b1, 32'h13A01005, 32'h0000_0500);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("ne.cond", 64'(out_cond), 64'(4'h1));
`ifdef COND_EVAL_EN
    exp_ne_z = 1'b0;
`else
    exp_ne_z = 1'b1;
`endif
    flags = 4'b0100;
    #1;
    check("ne.exec_z", 64'(out_exec), 64'(exp_ne_z));
    flags = 4'b0000;
    #1;
    check("ne.exec_nz", 64'(out_exec), 64'(1));
    out_ready = 1'b1;
    step();
    check("ne.drain", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_decode_pipe.md
# instr_decode_pipe

Registered, back-pressured instruction decode stage for the ARM-style datapath. It buffers fetched 32-bit instructions in a parametrised queue and splits each one into op, funct, cond, register indices and an extended immediate. Results are held in an output register with a valid/ready handshake, and a flush input squashes everything in flight on a taken branch. It sits between the fetch unit and the register-file read / control unit.

## Interface
- `DEPTH`, 2: instruction queue entries; power of two, at least 2.
- `REG_W`, 4: register index width.
- `IMM_W`, 32: width of the extended immediate.
- `clk` in 1: the only clock; everything samples on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: the stage accepts this cycle.
- `in_instr` in 32: raw instruction.
- `in_pc` in 32: PC of `in_instr`.
- `flush` in 1: squash the queue and the output register.
- `flags` in 4: NZCV flags; used only with `COND_EVAL_EN`.
- `out_valid` out 1: decoded instruction available.
- `out_ready` in 1: consumer takes it.
- `out_op` out 2: instr[27:26].
- `out_funct` out 6: operation function field.
- `out_cond` out 4: instr[31:28].
- `out_rn`, `out_rm`, `out_rd` out `REG_W`: register indices.
- `out_imm` out `IMM_W`: extended immediate.
- `out_rot` out 4: rotate field for data-processing immediates.
- `out_pc` out 32: PC of the decoded instruction.
- `out_illegal` out 1: op==3.
- `out_exec` out 1: condition passes.

## Operation
- **Accept:** a transfer occurs when `in_valid && in_ready`. `in_ready = !full && !flush`. There is no pass-through when the queue is full, even if a pop happens in the same cycle.
- **Load:** the output register loads the queue head when the queue is non-empty and `(!out_valid || out_ready)`. The pop and the load happen on the same edge.
- **Decode rules** (I = instr[25]):
  - **op=0, data-processing:**
    - Rn=[19:16], Rd=[15:12], funct=[25:20].
    - I=1: imm = zero-extended [7:0], rot=[11:8], Rm=0.
    - I=0: imm=0, rot=0, Rm=[3:0].
  - **op=1, memory:**
    - Rn, Rd and funct as for op=0.
    - I=0: imm = zero-extended [11:0], Rm=0.
    - I=1: Rm=[3:0], imm=0.
    - rot=0.
  - **op=2, branch:**
    - funct = {4'b0, [25:24]}.
    - imm = sign-extended {[23:0], 2'b00} to `IMM_W`.
    - Rn=Rm=Rd=0, rot=0.
  - **op=3:** all fields 0 and `out_illegal`=1. The instruction still flows through the handshake.
- **Register indices:** indices are zero-extended to `REG_W` when `REG_W`>4.
- **Flush:**
  - The edge with `flush`=1 empties the queue (pointers reset) and clears `out_valid`.
  - Nothing is accepted on that edge.
  - `flush` overrides a simultaneous load and a simultaneous push.
- **Output stability:** while `out_valid && !out_ready`, every out_* field holds stable.

## Timing
- **Reset** (async assert, sync release):
  - queue empty, `in_ready`=1, `out_valid`=0;
  - all out_* data fields 0, `out_illegal`=0;
  - `out_exec` follows the `COND_EVAL_EN` rule.
- **Latency:** an instruction pushed at edge N is visible on out_* after edge N+1 if the output register is free. Minimum latency is 2 cycles.
- **Throughput:** one instruction per cycle when `out_ready` stays high.
- **Queue boundaries:**
  - Full (count==`DEPTH`) deasserts `in_ready` in the same cycle.
  - Empty with `out_ready`=1 deasserts `out_valid` after the edge.
  - Pointers wrap modulo `DEPTH`.
- **Flush timing:** `flush` mid-stall is honoured immediately; `in_ready` returns to 1 the cycle after.

## Configuration
- **`COND_EVAL_EN` defined:** `out_exec` is combinational from `out_cond` and the live `flags` input. It implements all 15 ARM conditions (EQ…AL); code 4'b1111 evaluates to 0.
- **`COND_EVAL_EN` undefined:** `out_exec` is tied to 1 and `flags` is ignored.

## Structure
- **Package `decode_pkg`:**
  - op enum `OP_DP`/`OP_MEM`/`OP_BR`/`OP_ILL`;
  - cond-code localparams;
  - `decoded_instr_t` struct holding all out_* fields;
  - `decode()` function, parametrised by `IMM_W` via a max-width struct plus truncation.
- **Sub-module `instr_fifo`:**
  - generic `DEPTH`×(32+32) queue;
  - ports: push, pop, clear, full, empty, head.
- **Top level:** output register, handshake logic and condition evaluation.

## Test plan
- **Data-processing immediate:** push 0xE3A01005 with `out_ready`=1.
  - Two cycles later: op=0, funct=0x3A, Rn=0, Rd=1, imm=5, rot=0, Rm=0, `out_exec`=1.
- **Branch sign extension:** push 0xEAFFFFFE.
  - Expect op=2, funct=0x02, imm=0xFFFFFFF8.
- **Memory, op=3, and `REG_W`:**
  - Memory 0xE5912004 → Rn=1, Rd=2, imm=4.
  - 0xEC000000 → `out_illegal`=1, all fields 0.
  - With `REG_W`=5: Rn=5'b00001.
- **Back-pressure:** `out_ready`=0, push `DEPTH`+1 instructions.
  - After `DEPTH` pushes plus one load, `in_ready`=0.
  - Output holds its first value stable.
  - Releasing `out_ready` drains the instructions in order.
- **Flush:** assert `flush` with the queue full and `out_valid`=1.
  - Next cycle `out_valid`=0, empty, `in_ready`=1.
  - A push presented on the flush cycle is dropped.
- **`COND_EVAL_EN`:** NE instruction (cond=1) with `flags`=4'b0100 → `out_exec`=0; with `flags`=0 → 1.
  - Build without the macro → `out_exec`=1 for both.
